// File: rtl/program_loader_if.sv
// Host byte link and instruction-memory write port of the program loader.
// slave = loader side, master = host/memory side.
interface program_loader_if #(
  parameter int IW = 24,
  parameter int PW = 8
) ();
  logic          byteValid;
  logic [7:0]    byteData;
  logic          byteReady;
  logic          memWriteEnable;
  logic [PW-1:0] memAddress;
  logic [IW-1:0] memData;

  modport master (
    output byteValid, byteData,
    input  byteReady, memWriteEnable,
    input  memAddress, memData
  );

  modport slave (
    input  byteValid, byteData,
    output byteReady, memWriteEnable,
    output memAddress, memData
  );
endinterface

// File: rtl/program_loader.sv
// Frames a host byte stream into instruction-memory writes; holds the CPU in reset while loading.
// Define PROGRAM_LOADER_CHECKSUM_EN to require and verify a trailing CHK byte.
module program_loader #(
  parameter int          INSTRUCTION_WIDTH = 24,
  parameter int          PC_WIDTH          = 8,
  parameter logic [7:0]  START_BYTE        = 8'hA5
) (
  input  logic           clock,
  input  logic           isResetN,
  program_loader_if.slave bus,
  output logic           holdCpuReset,
  output logic           loadDone,
  output logic           loadError
);

  localparam int IW  = INSTRUCTION_WIDTH;
  localparam int BPW = IW / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LENGTH = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  localparam logic [2:0] ERROR  = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          sum_q, sum_d;
  logic [7:0]          wcnt_q, wcnt_d;
  logic [BCW-1:0]      bcnt_q, bcnt_d;
  logic [PC_WIDTH-1:0] cnt_q, cnt_d;
  logic [IW-1:0]       word_q, word_d;
  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic [IW-1:0]       data_q, data_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic       acc;
  logic [7:0] b;
  logic       last_byte;
  logic       last_word;

  assign acc       = bus.byteValid & ready_q;
  assign b         = bus.byteData;
  assign last_byte = (bcnt_q == BCW'(BPW - 1));
  assign last_word = (wcnt_q == (len_q - 8'd1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    ready_d = 1'b1;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    if (acc) begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (b == START_BYTE) begin
            state_d = LENGTH;
            hold_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
        LENGTH: begin
          len_d  = b;
          sum_d  = b;
          cnt_d  = '0;
          wcnt_d = '0;
          bcnt_d = '0;
          if (b == 8'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
`endif
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          word_d = (word_q << 8) | IW'(b);
          sum_d  = sum_q + b;
          if (last_byte) begin
            bcnt_d = '0;
            we_d   = 1'b1;
            data_d = word_d;
            addr_d = cnt_q;
            cnt_d  = cnt_q + 1'b1;
            wcnt_d = wcnt_q + 8'd1;
            if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state_d = CHECK;
`else
              state_d = DONE;
              done_d  = 1'b1;
              hold_d  = 1'b0;
`endif
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        CHECK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          // Any byte here is CHK, even one equal to the start marker
          if (b == sum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      state_q <= IDLE;
      len_q   <= '0;
      sum_q   <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.byteReady      = ready_q;
  assign bus.memWriteEnable = we_q;
  assign bus.memAddress     = addr_q;
  assign bus.memData        = data_q;
  assign holdCpuReset       = hold_q;
  assign loadDone           = done_q;
  assign loadError          = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: random frames from a byte-level model,
// writes checked by a negedge monitor against a queue of expected writes.
module tb_program_loader;
  localparam int IW  = 24;
  localparam int PW  = 8;
  localparam int BPW = IW / 8;

  logic clock    = 1'b0;
  logic isResetN = 1'b1;
  logic holdCpuReset, loadDone, loadError;

  program_loader_if #(.IW(IW), .PW(PW)) bus ();

  program_loader #(
    .INSTRUCTION_WIDTH(IW),
    .PC_WIDTH(PW),
    .START_BYTE(8'hA5)
  ) dut (
    .clock(clock),
    .isResetN(isResetN),
    .bus(bus),
    .holdCpuReset(holdCpuReset),
    .loadDone(loadDone),
    .loadError(loadError)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [PW-1:0] a;
    logic [IW-1:0] d;
    int            c;
  } exp_t;

  exp_t          sb[$];
  logic [IW-1:0] preset[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clock) begin
    exp_t e;
    if (isResetN && bus.memWriteEnable === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                 bus.memAddress, bus.memData);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(bus.memAddress), 32'(e.a));
        check("wr_data", 32'(bus.memData), 32'(e.d));
        check("wr_cycle", cyc, e.c);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.byteValid = 1'b1;
    bus.byteData  = b;
    while (bus.byteReady !== 1'b1 && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 20) begin
      tests++;
      fails++;
      $display("FAIL byte_ready_timeout: got ready=%b expected 1", bus.byteReady);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int k);
    bus.byteValid = 1'b0;
    repeat (k) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_status(input string tag, input logic d,
                              input logic e, input logic h);
    check({tag, "_done"}, 32'(loadDone), 32'(d));
    check({tag, "_err"}, 32'(loadError), 32'(e));
    check({tag, "_hold"}, 32'(holdCpuReset), 32'(h));
  endtask

  task automatic send_frame(input int n, input bit bad, input bit gaps,
                            input bit force_a5);
    logic [7:0]    sum;
    logic [7:0]    b;
    logic [IW-1:0] w;
    bit            ok;
    sum = n[7:0];
    send(8'hA5);
    check_status("start", 1'b0, 1'b0, 1'b1);
    send(n[7:0]);
    for (int i = 0; i < n; i++) begin
      if (preset.size() > 0) w = preset.pop_front();
      else w = IW'($urandom);
      if (force_a5 && $urandom_range(0, 2) == 0) w[15:8] = 8'hA5;
      for (int k = BPW - 1; k >= 0; k--) begin
        b = w[k*8 +: 8];
        send(b);
        sum = sum + b;
        if (k == 0) sb.push_back('{a: PW'(i), d: w, c: cyc});
        if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ok = !bad;
    send(bad ? sum + 8'd1 : sum);
`else
    ok = 1'b1;
`endif
    if (ok) check_status("end_ok", 1'b1, 1'b0, 1'b0);
    else check_status("end_bad", 1'b0, 1'b1, 1'b1);
    bus.byteValid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.byteValid = 1'b0;
    bus.byteData  = 8'h00;
    #2 isResetN = 1'b0;
    #1;
    check("rst_ready", 32'(bus.byteReady), 0);
    check("rst_we", 32'(bus.memWriteEnable), 0);
    check("rst_addr", 32'(bus.memAddress), 0);
    check("rst_data", 32'(bus.memData), 0);
    check_status("rst", 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    isResetN = 1'b1;
    #1;
    check("rel_ready_before", 32'(bus.byteReady), 0);
    @(posedge clock);
    #1;
    check("rel_ready_after", 32'(bus.byteReady), 1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    preset.push_back(24'h112233);
    preset.push_back(24'h445566);
    send_frame(2, 1'b0, 1'b0, 1'b0);
    idle(2);
    preset.push_back(24'h112233);
    preset.push_back(24'h445566);
    send_frame(2, 1'b1, 1'b0, 1'b0);
    send(8'h3C);
    bus.byteValid = 1'b0;
    check_status("err_persist", 1'b0, 1'b1, 1'b1);
    idle(1);
`else
    preset.push_back(24'hAABBCC);
    send_frame(1, 1'b0, 1'b0, 1'b0);
    idle(2);
`endif

    send_frame(0, 1'b0, 1'b0, 1'b0);
    send(8'h00);
    send(8'h3C);
    bus.byteValid = 1'b0;
    check_status("junk_ignored", 1'b1, 1'b0, 1'b0);
    send(8'hA5);
    bus.byteValid = 1'b0;
    check_status("restart", 1'b0, 1'b0, 1'b1);
    send(8'h00);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    bus.byteValid = 1'b0;
    check_status("len0_again", 1'b1, 1'b0, 1'b0);
    idle(2);

    for (int r = 0; r < 8; r++) begin
      send_frame($urandom_range(1, 12), $urandom_range(0, 3) == 0,
                 r[0], 1'b1);
      idle($urandom_range(0, 3));
    end

    send_frame(255, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Reset in the middle of a frame, after four payload bytes
    send(8'hA5);
    send(8'h03);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    sb.push_back('{a: PW'(0), d: 24'h010203, c: cyc});
    send(8'h04);
    bus.byteValid = 1'b0;
    isResetN = 1'b0;
    #1;
    check("mid_ready", 32'(bus.byteReady), 0);
    check("mid_we", 32'(bus.memWriteEnable), 0);
    check("mid_addr", 32'(bus.memAddress), 0);
    check("mid_data", 32'(bus.memData), 0);
    check_status("mid_rst", 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    isResetN = 1'b1;
    @(posedge clock);
    #1;
    send_frame(3, 1'b0, 1'b1, 1'b0);
    idle(4);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
